mw_add_ctrl: RTL and testbench

//  Multi-word add/subtract sequencer built around one shared rca32.

---
 rtl/mw_add_ctrl_pkg.sv | 19 +
 rtl/mw_add_ctrl_rca32.sv | 28 ++
 rtl/mw_add_ctrl.sv | 135 +++++++++++++
 tb/tb_mw_add_ctrl.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/mw_add_ctrl_pkg.sv
// Shared definitions for the multi-word add/subtract sequencer.
//   WORD_W    : width of one slice handled by the shared adder
//   state_e   : sequencer states (IDLE -> RUN -> DONE -> IDLE)
//   idx_width : word-index width, never narrower than one bit
package mw_add_ctrl_pkg;

  localparam int unsigned WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

  function automatic int unsigned idx_width(input int unsigned words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

endpackage

// File: rtl/mw_add_ctrl_rca32.sv
// rca32: 32-bit ripple-carry adder used as the shared word slice.
//   s  : out 32  sum
//   co : out 1   carry-out
//   a  : in  32  addend
//   b  : in  32  addend
//   ci : in  1   carry-in
module rca32 (
  output logic [31:0] s,
  output logic        co,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        ci
);

  logic [32:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = ci;
    for (int unsigned i = 0; i < 32; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    co = c[32];
  end

endmodule

// File: rtl/mw_add_ctrl.sv
// mw_add_ctrl: multi-word add/subtract sequencer around one shared rca32.
// Operands are captured on an accepted start and summed one 32-bit word per
// cycle, LSW first, with the inter-word carry held in a register.
//   clk     : in  1         clock
//   reset_n : in  1         synchronous active-low reset
//   start   : in  1         request, accepted only when idle
//   op_sub  : in  1         0: a+b+ci, 1: a-b
//   ci      : in  1         carry-in for add
//   a, b    : in  WORDS*32  operands, sampled on the accepting edge
//   busy    : out 1         operation in progress (RUN or DONE)
//   done    : out 1         one-cycle result-valid pulse
//   s       : out WORDS*32  result, held until the next accepted start
//   co      : out 1         final carry-out (subtract: 1 = no borrow)
//   ovf     : out 1         signed overflow of the full-width result
module mw_add_ctrl
  import mw_add_ctrl_pkg::*;
#(
  parameter int unsigned WORDS = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic                    op_sub,
  input  logic                    ci,
  input  logic [WORDS*WORD_W-1:0] a,
  input  logic [WORDS*WORD_W-1:0] b,
  output logic                    busy,
  output logic                    done,
  output logic [WORDS*WORD_W-1:0] s,
  output logic                    co,
  output logic                    ovf
);

  localparam int unsigned W  = WORDS * WORD_W;
  localparam int unsigned IW = idx_width(WORDS);

  state_e          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            carry_q, carry_d;
  logic            sub_q, sub_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    s_q, s_d;
  logic            co_q, co_d;
  logic            ovf_q, ovf_d;

  logic [WORD_W-1:0] a_w, b_w, sum_w;
  logic              rca_co;
  logic              last_w;

  // Current word slice; B is inverted word-wise for subtraction.
  always_comb begin
    a_w    = a_q[idx_q*WORD_W +: WORD_W];
    b_w    = b_q[idx_q*WORD_W +: WORD_W] ^ {WORD_W{sub_q}};
    last_w = (idx_q == IW'(WORDS - 1));
  end

  rca32 U0_rca32 (
    .s  (sum_w),
    .co (rca_co),
    .a  (a_w),
    .b  (b_w),
    .ci (carry_q)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    sub_d   = sub_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    co_d    = co_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          sub_d   = op_sub;
          carry_d = op_sub ? 1'b1 : ci;
          idx_d   = '0;
          s_d     = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        s_d[idx_q*WORD_W +: WORD_W] = sum_w;
        carry_d = rca_co;
        idx_d   = idx_q + 1'b1;
        if (last_w) begin
          co_d    = rca_co;
          // Top-word sign bits decide overflow; b_w is already inverted for sub.
          ovf_d   = (a_w[WORD_W-1] == b_w[WORD_W-1]) &&
                    (sum_w[WORD_W-1] != a_w[WORD_W-1]);
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      sub_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      co_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      sub_q   <= sub_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      co_q    <= co_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign s    = s_q;
  assign co   = co_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_mw_add_ctrl.sv
module tb_mw_add_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset_n;
  logic         start4, op_sub4, ci4;
  logic [127:0] a4, b4, s4;
  logic         busy4, done4, co4, ovf4;
  logic         start1, op_sub1, ci1;
  logic [31:0]  a1, b1, s1;
  logic         busy1, done1, co1, ovf1;

  mw_add_ctrl #(.WORDS(4)) u_dut4 (
    .clk(clk), .reset_n(reset_n), .start(start4), .op_sub(op_sub4), .ci(ci4),
    .a(a4), .b(b4), .busy(busy4), .done(done4), .s(s4), .co(co4), .ovf(ovf4)
  );

  mw_add_ctrl #(.WORDS(1)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .start(start1), .op_sub(op_sub1), .ci(ci1),
    .a(a1), .b(b1), .busy(busy1), .done(done1), .s(s1), .co(co1), .ovf(ovf1)
  );

  typedef struct {
    logic [127:0] s;
    logic         co;
    logic         ovf;
    int unsigned  cyc;
    int unsigned  id;
  } exp_t;

  exp_t q4[$];
  exp_t q1[$];

  int unsigned total = 0;
  int unsigned bad   = 0;
  int unsigned cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  // Monitor: pops the scoreboard whenever a DUT presents done.
  always @(negedge clk) begin
    exp_t e;
    if (done4 === 1'b1) begin
      if (q4.size() == 0) check("w4_unexpected_done", done4, 0);
      else begin
        e = q4.pop_front();
        check($sformatf("w4_s[%0d]", e.id),    s4,    e.s);
        check($sformatf("w4_co[%0d]", e.id),   co4,   e.co);
        check($sformatf("w4_ovf[%0d]", e.id),  ovf4,  e.ovf);
        check($sformatf("w4_busy[%0d]", e.id), busy4, 1);
        check($sformatf("w4_lat[%0d]", e.id),  cyc,   e.cyc);
      end
    end
    if (done1 === 1'b1) begin
      if (q1.size() == 0) check("w1_unexpected_done", done1, 0);
      else begin
        e = q1.pop_front();
        check($sformatf("w1_s[%0d]", e.id),    {96'd0, s1}, e.s);
        check($sformatf("w1_co[%0d]", e.id),   co1,   e.co);
        check($sformatf("w1_ovf[%0d]", e.id),  ovf1,  e.ovf);
        check($sformatf("w1_busy[%0d]", e.id), busy1, 1);
        check($sformatf("w1_lat[%0d]", e.id),  cyc,   e.cyc);
      end
    end
  end

  // Issue one accepted request; done is due at the negedge after edge k+WORDS.
  task automatic issue4(input int unsigned id, input logic sub, input logic c,
                        input logic [127:0] a, input logic [127:0] b,
                        input logic [127:0] es, input logic eco, input logic eovf,
                        input logic push);
    exp_t e;
    @(negedge clk);
    start4 = 1'b1; op_sub4 = sub; ci4 = c; a4 = a; b4 = b;
    @(posedge clk);
    e.s = es; e.co = eco; e.ovf = eovf; e.id = id; e.cyc = cyc + 4 + 1;
    if (push) q4.push_back(e);
    #1;
    start4 = 1'b0; a4 = ~a; b4 = ~b; op_sub4 = ~sub; ci4 = ~c;
  endtask

  task automatic issue1(input int unsigned id, input logic sub, input logic c,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] es, input logic eco, input logic eovf);
    exp_t e;
    @(negedge clk);
    start1 = 1'b1; op_sub1 = sub; ci1 = c; a1 = a; b1 = b;
    @(posedge clk);
    e.s = {96'd0, es}; e.co = eco; e.ovf = eovf; e.id = id; e.cyc = cyc + 1 + 1;
    q1.push_back(e);
    #1;
    start1 = 1'b0; a1 = ~a; b1 = ~b; op_sub1 = ~sub; ci1 = ~c;
  endtask

  task automatic wait_idle();
    int unsigned n = 0;
    while ((q4.size() != 0 || q1.size() != 0 || busy4 || busy1) && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) begin
      total++;
      bad++;
      $display("FAIL wait_idle timeout: pending4=%0d pending1=%0d busy4=%b busy1=%b",
               q4.size(), q1.size(), busy4, busy1);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    start4 = 1'b0; op_sub4 = 1'b0; ci4 = 1'b0; a4 = '0; b4 = '0;
    start1 = 1'b0; op_sub1 = 1'b0; ci1 = 1'b0; a1 = '0; b1 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy4", busy4, 0);
    check("rst_done4", done4, 0);
    check("rst_s4",    s4,    0);
    check("rst_co4",   co4,   0);
    check("rst_ovf4",  ovf4,  0);
    check("rst_busy1", busy1, 0);
    check("rst_s1",    s1,    0);
    reset_n = 1'b1;

    // T1: all-ones + 1 wraps to zero with carry-out
    issue4(1, 0, 0, {128{1'b1}}, 128'd1, 128'd0, 1, 0, 1);
    wait_idle();
    // T2: carry ripples across three word boundaries
    issue4(2, 0, 0, 128'h0000_0000_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 128'd1,
           128'h0000_0001_0000_0000_0000_0000_0000_0000, 0, 0, 1);
    wait_idle();
    // T3: subtract with and without borrow
    issue4(3, 1, 0, 128'd5, 128'd7, {{127{1'b1}}, 1'b0}, 0, 0, 1);
    wait_idle();
    issue4(4, 1, 0, 128'd7, 128'd5, 128'd2, 1, 0, 1);
    wait_idle();
    // ci is ignored when subtracting: 0 - 0 = 0, no borrow
    issue4(5, 1, 1, 128'd0, 128'd0, 128'd0, 1, 0, 1);
    wait_idle();
    // T4: carry-in pushes max positive into negative range
    issue4(6, 0, 1, {1'b0, {127{1'b1}}}, 128'd0, {1'b1, 127'd0}, 0, 1, 1);
    wait_idle();
    // T5: starts during RUN and DONE are ignored
    issue4(7, 0, 0, 128'd3, 128'd4, 128'd7, 0, 0, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      start4 = 1'b1; op_sub4 = 1'b1; a4 = 128'hDEAD; b4 = 128'hBEEF;
    end
    @(negedge clk);
    start4 = 1'b0;
    wait_idle();
    // Subtract overflow: most negative - 1
    issue4(8, 1, 0, {1'b1, 127'd0}, 128'd1, {1'b0, {127{1'b1}}}, 1, 1, 1);
    wait_idle();

    // T6: reset during RUN at idx=2 discards the operation
    issue4(9, 0, 0, 128'h1234, 128'h5678, 128'd0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    check("t6_busy4", busy4, 0);
    check("t6_done4", done4, 0);
    check("t6_s4",    s4,    0);
    check("t6_co4",   co4,   0);
    check("t6_ovf4",  ovf4,  0);
    repeat (8) @(negedge clk);
    issue4(10, 0, 0, 128'h0123_4567_89AB_CDEF_0000_0001_FFFF_FFFF, 128'd1,
           128'h0123_4567_89AB_CDEF_0000_0002_0000_0000, 0, 0, 1);
    wait_idle();

    // WORDS=1 instance: single RUN cycle
    issue1(11, 0, 0, 32'hFFFF_FFFF, 32'd1, 32'd0, 1, 0);
    wait_idle();
    issue1(12, 0, 0, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 0, 1);
    wait_idle();
    issue1(13, 1, 0, 32'd3, 32'd5, 32'hFFFF_FFFE, 0, 0);
    wait_idle();

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
